// File: rtl/imem_load_ctrl.sv
// -----------------------------------------------------------------------------
// imem_load_ctrl
//
// Instruction-memory program loader. While idle, the instruction memory
// address follows the core fetch PC. A load_req starts a byte-stream load.
// Bytes are packed little-endian into 32-bit words. Each complete word is
// written to consecutive word addresses starting at 0. The core is stalled
// for the whole load and receives a one-cycle restart pulse when it finishes.
//
// Parameters
//   DEPTH          number of 32-bit words in the instruction memory
//   ADDR_W         word-address width, log2(DEPTH)
//
// Ports
//   clk            clock, rising edge
//   rst_n          asynchronous active-low reset
//   load_req       pulse: start a program load (honoured only when idle)
//   load_end       pulse: finish the load early (honoured only while loading)
//   byte_valid     a loader byte is present on byte_data
//   byte_data      loader byte
//   byte_ready     block accepts a byte this cycle
//   fetch_addr     core PC byte address
//   mem_addr       instruction-memory word address
//   mem_we         instruction-memory write enable
//   mem_wdata      instruction-memory write data
//   core_stall     holds the core during a load
//   core_rst_pulse one-cycle core restart after a load
//   load_count     words written by the last or current load
//   load_busy      loader is not idle
// -----------------------------------------------------------------------------
module imem_load_ctrl #(
    parameter int unsigned DEPTH  = 32,
    parameter int unsigned ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_req,
    input  logic              load_end,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    input  logic [31:0]       fetch_addr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [31:0]       mem_wdata,
    output logic              core_stall,
    output logic              core_rst_pulse,
    output logic [ADDR_W:0]   load_count,
    output logic              load_busy
);

    typedef enum logic [1:0] {StIdle, StLoad, StWrite, StDone} state_e;

    localparam logic [ADDR_W-1:0] LastAddr  = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   FullCount = (ADDR_W + 1)'(DEPTH);

    state_e            state_q, state_d;
    logic [1:0]        byte_idx_q, byte_idx_d;
    logic [31:0]       buf_q, buf_d;
    logic [ADDR_W-1:0] wptr_q, wptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    // load_end arrived together with a word-completing byte or mid-word;
    // finish after the pending write instead of returning to LOAD.
    logic              end_pend_q, end_pend_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            byte_idx_q <= '0;
            buf_q      <= '0;
            wptr_q     <= '0;
            count_q    <= '0;
            end_pend_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            byte_idx_q <= byte_idx_d;
            buf_q      <= buf_d;
            wptr_q     <= wptr_d;
            count_q    <= count_d;
            end_pend_q <= end_pend_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        byte_idx_d     = byte_idx_q;
        buf_d          = buf_q;
        wptr_d         = wptr_q;
        count_d        = count_q;
        end_pend_d     = end_pend_q;
        mem_addr       = fetch_addr[ADDR_W+1:2];
        mem_we         = 1'b0;
        mem_wdata      = buf_q;
        byte_ready     = 1'b0;
        core_stall     = 1'b0;
        core_rst_pulse = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (load_req) begin
                    state_d    = StLoad;
                    byte_idx_d = '0;
                    buf_d      = '0;
                    wptr_d     = '0;
                    count_d    = '0;
                    end_pend_d = 1'b0;
                end
            end

            StLoad: begin
                byte_ready = 1'b1;
                core_stall = 1'b1;
                if (byte_valid) begin
                    buf_d[{byte_idx_q, 3'b000} +: 8] = byte_data;
                    byte_idx_d                       = byte_idx_q + 2'd1;
                end
                if (byte_valid && byte_idx_q == 2'd3) begin
                    state_d    = StWrite;
                    end_pend_d = load_end;
                end else if (load_end) begin
                    // Byte taken first; an empty word means nothing to flush.
                    if (byte_idx_d == 2'd0) begin
                        state_d = StDone;
                    end else begin
                        state_d    = StWrite;
                        end_pend_d = 1'b1;
                    end
                end
            end

            StWrite: begin
                mem_we     = 1'b1;
                mem_addr   = wptr_q;
                core_stall = 1'b1;
                count_d    = count_q + 1'b1;
                // Saturate so the pointer never leaves the memory range.
                if (wptr_q != LastAddr) begin
                    wptr_d = wptr_q + 1'b1;
                end
                byte_idx_d = '0;
                buf_d      = '0;
                end_pend_d = 1'b0;
                if (count_d == FullCount || end_pend_q) begin
                    state_d = StDone;
                end else begin
                    state_d = StLoad;
                end
            end

            StDone: begin
                core_stall     = 1'b1;
                core_rst_pulse = 1'b1;
                state_d        = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign load_count = count_q;
    assign load_busy  = (state_q != StIdle);

endmodule

// File: tb/tb_imem_load_ctrl.sv
module tb_imem_load_ctrl;

    localparam int DEPTH  = 32;
    localparam int ADDR_W = 5;

    logic              clk;
    logic              rst_n;
    logic              load_req;
    logic              load_end;
    logic              byte_valid;
    logic [7:0]        byte_data;
    logic              byte_ready;
    logic [31:0]       fetch_addr;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [31:0]       mem_wdata;
    logic              core_stall;
    logic              core_rst_pulse;
    logic [ADDR_W:0]   load_count;
    logic              load_busy;

    imem_load_ctrl #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .load_req       (load_req),
        .load_end       (load_end),
        .byte_valid     (byte_valid),
        .byte_data      (byte_data),
        .byte_ready     (byte_ready),
        .fetch_addr     (fetch_addr),
        .mem_addr       (mem_addr),
        .mem_we         (mem_we),
        .mem_wdata      (mem_wdata),
        .core_stall     (core_stall),
        .core_rst_pulse (core_rst_pulse),
        .load_count     (load_count),
        .load_busy      (load_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Write monitor: records every memory write and restart pulse.
    int          wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    int          rst_pulses = 0;

    always @(negedge clk) begin
        if (mem_we) begin
            wr_addr_q.push_back(int'(mem_addr));
            wr_data_q.push_back(mem_wdata);
        end
        if (core_rst_pulse) rst_pulses++;
    end

    task automatic clear_mon();
        wr_addr_q.delete();
        wr_data_q.delete();
        rst_pulses = 0;
    endtask

    // All driver tasks start and end on a falling edge.
    task automatic do_load_req();
        load_req = 1'b1;
        @(negedge clk);
        load_req = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit with_end, input int gap);
        int n;
        n          = 0;
        byte_valid = 1'b1;
        byte_data  = b;
        while (!byte_ready && n < 16) begin
            @(negedge clk);
            n++;
        end
        if (!byte_ready) begin
            check_eq("byte_ready_timeout", 32'(byte_ready), 32'd1);
        end else begin
            load_end = with_end;
            @(negedge clk);
            load_end = 1'b0;
        end
        byte_valid = 1'b0;
        byte_data  = 8'($urandom);
        repeat (gap) @(negedge clk);
    endtask

    task automatic send_end();
        int n;
        n = 0;
        while (!byte_ready && n < 16) begin
            @(negedge clk);
            n++;
        end
        if (!byte_ready) begin
            check_eq("end_ready_timeout", 32'(byte_ready), 32'd1);
        end else begin
            load_end = 1'b1;
            @(negedge clk);
            load_end = 1'b0;
        end
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (load_busy && n < 64) begin
            @(negedge clk);
            n++;
        end
        check_eq({tag, "_idle"}, 32'(load_busy), 32'd0);
    endtask

    // Reference model: the byte stream packed little-endian into words,
    // zero-padded, at most DEPTH words, written to addresses 0,1,2,...
    logic [7:0] stim[$];

    task automatic run_load(input bit end_last, input int gap_max, input string tag);
        int          nb;
        int          nw;
        logic [31:0] exp_w[$];
        nb = stim.size();
        nw = (nb + 3) / 4;
        if (nw > DEPTH) nw = DEPTH;
        for (int w = 0; w < nw; w++) begin
            logic [31:0] word;
            word = '0;
            for (int k = 0; k < 4; k++) begin
                if (4 * w + k < nb) word[8*k +: 8] = stim[4*w+k];
            end
            exp_w.push_back(word);
        end

        clear_mon();
        do_load_req();
        check_eq({tag, "_stall"}, 32'(core_stall), 32'd1);
        for (int i = 0; i < nb; i++) begin
            send_byte(stim[i], end_last && (i == nb - 1), $urandom_range(0, gap_max));
        end
        if (nb < 4 * DEPTH && !(end_last && nb > 0)) send_end();
        wait_idle(tag);

        check_eq({tag, "_nwrites"}, 32'(wr_addr_q.size()), 32'(nw));
        for (int i = 0; i < nw && i < wr_addr_q.size(); i++) begin
            check_eq({tag, "_wr_addr"}, 32'(wr_addr_q[i]), 32'(i));
            check_eq({tag, "_wr_data"}, wr_data_q[i], exp_w[i]);
        end
        check_eq({tag, "_count"}, 32'(load_count), 32'(nw));
        check_eq({tag, "_rst_pulses"}, 32'(rst_pulses), 32'd1);
        check_eq({tag, "_stall_after"}, 32'(core_stall), 32'd0);
    endtask

    initial begin
        logic [31:0] fa;
        rst_n      = 1'b1;
        load_req   = 1'b0;
        load_end   = 1'b0;
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        fetch_addr = 32'h0;
        #2 rst_n = 1'b0;
        #10;
        check_eq("rst_busy", 32'(load_busy), 32'd0);
        check_eq("rst_count", 32'(load_count), 32'd0);
        check_eq("rst_ready", 32'(byte_ready), 32'd0);
        check_eq("rst_rstpulse", 32'(core_rst_pulse), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Idle address pass-through.
        fetch_addr = 32'h0000_000B;
        #1;
        check_eq("idle_addr_b", 32'(mem_addr), 32'd2);
        check_eq("idle_we", 32'(mem_we), 32'd0);
        check_eq("idle_stall", 32'(core_stall), 32'd0);
        check_eq("idle_busy", 32'(load_busy), 32'd0);
        for (int i = 0; i < 4; i++) begin
            fa         = $urandom;
            fetch_addr = fa;
            #1;
            check_eq("idle_addr_rand", 32'(mem_addr), (fa >> 2) % DEPTH);
        end
        @(negedge clk);

        // One word, then back in LOAD.
        clear_mon();
        do_load_req();
        send_byte(8'h13, 1'b0, 0);
        send_byte(8'h05, 1'b0, 0);
        send_byte(8'h50, 1'b0, 0);
        send_byte(8'h00, 1'b0, 0);
        @(negedge clk);
        #1;
        check_eq("w1_nwrites", 32'(wr_addr_q.size()), 32'd1);
        if (wr_addr_q.size() > 0) begin
            check_eq("w1_addr", 32'(wr_addr_q[0]), 32'd0);
            check_eq("w1_data", wr_data_q[0], 32'h0050_0513);
        end
        check_eq("w1_count", 32'(load_count), 32'd1);
        check_eq("w1_back_in_load", 32'(byte_ready), 32'd1);
        send_end();
        wait_idle("w1");
        check_eq("w1_rst_pulses", 32'(rst_pulses), 32'd1);

        // Full memory with byte_valid held high: auto finish.
        stim.delete();
        for (int i = 0; i < 4 * DEPTH; i++) stim.push_back(8'($urandom));
        run_load(1'b0, 0, "full");

        // Early end with a partial word.
        stim.delete();
        stim.push_back(8'h11); stim.push_back(8'h22); stim.push_back(8'h33);
        stim.push_back(8'h44); stim.push_back(8'hAA); stim.push_back(8'hBB);
        run_load(1'b0, 1, "early");

        // Bytes in IDLE are ignored; load_count holds.
        clear_mon();
        for (int i = 0; i < 3; i++) begin
            byte_valid = 1'b1;
            byte_data  = 8'($urandom);
            load_end   = 1'b1;
            @(negedge clk);
        end
        byte_valid = 1'b0;
        load_end   = 1'b0;
        @(negedge clk);
        check_eq("idle_bytes_nwrites", 32'(wr_addr_q.size()), 32'd0);
        check_eq("idle_bytes_count", 32'(load_count), 32'd2);
        check_eq("idle_bytes_busy", 32'(load_busy), 32'd0);

        // load_req during LOAD is ignored.
        clear_mon();
        do_load_req();
        send_byte(8'hA1, 1'b0, 0);
        send_byte(8'hB2, 1'b0, 0);
        do_load_req();
        send_byte(8'hC3, 1'b0, 0);
        send_byte(8'hD4, 1'b0, 0);
        send_end();
        wait_idle("ignreq");
        check_eq("ignreq_nwrites", 32'(wr_addr_q.size()), 32'd1);
        if (wr_data_q.size() > 0) check_eq("ignreq_data", wr_data_q[0], 32'hD4C3_B2A1);
        check_eq("ignreq_count", 32'(load_count), 32'd1);

        // Reset mid-word discards the partial word.
        clear_mon();
        do_load_req();
        send_byte(8'h5A, 1'b0, 0);
        send_byte(8'hA5, 1'b0, 0);
        rst_n = 1'b0;
        #1;
        check_eq("midrst_busy", 32'(load_busy), 32'd0);
        check_eq("midrst_stall", 32'(core_stall), 32'd0);
        check_eq("midrst_count", 32'(load_count), 32'd0);
        check_eq("midrst_we", 32'(mem_we), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("midrst_nwrites", 32'(wr_addr_q.size()), 32'd0);
        check_eq("midrst_pulses", 32'(rst_pulses), 32'd0);

        // Randomized loads against the model.
        for (int it = 0; it < 12; it++) begin
            int nb;
            nb = ($urandom_range(0, 4) == 0) ? 4 * DEPTH : int'($urandom_range(0, 40));
            stim.delete();
            for (int i = 0; i < nb; i++) stim.push_back(8'($urandom));
            run_load(1'($urandom_range(0, 1)), $urandom_range(0, 2), "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/imem_load_ctrl.md
IMEM_LOAD_CTRL -- requirements
Module: imem_load_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 32: number of 32-bit words in the instruction memory.
REQ-002 SHALL have parameter ADDR_W, default 5: word-address width, equal to log2(DEPTH).
REQ-003 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
REQ-005 SHALL have port load_req, input, 1: single-cycle pulse that starts a program load.
REQ-006 SHALL have port load_end, input, 1: single-cycle pulse that terminates a load early.
REQ-007 SHALL have port byte_valid, input, 1: a loader byte is present on byte_data.
REQ-008 SHALL have port byte_data, input, 8: the loader byte.
REQ-009 SHALL have port byte_ready, output, 1: the block accepts a byte this cycle.
REQ-010 SHALL have port fetch_addr, input, 32: core PC byte address.
REQ-011 SHALL have port mem_addr, output, ADDR_W: instruction-memory word address.
REQ-012 SHALL have port mem_we, output, 1: instruction-memory write enable.
REQ-013 SHALL have port mem_wdata, output, 32: instruction-memory write data.
REQ-014 SHALL have port core_stall, output, 1: holds the core while a load is in progress.
REQ-015 SHALL have port core_rst_pulse, output, 1: one-cycle core restart after a load.
REQ-016 SHALL have port load_count, output, ADDR_W+1: number of words written by the last or current load.
REQ-017 SHALL have port load_busy, output, 1: the state machine is in any state other than IDLE.

Function
REQ-018 SHALL implement an FSM with states IDLE, LOAD, WRITE, DONE.
REQ-019 In IDLE: mem_addr = fetch_addr[ADDR_W+1:2] (combinational); byte offset bits and upper bits are ignored; mem_we=0, byte_ready=0, core_stall=0.
REQ-020 IDLE + load_req -> LOAD on the next edge; on that transition clear the write pointer, load_count and byte index, and zero the word buffer.
REQ-021 In LOAD: byte_ready=1, core_stall=1, mem_we=0.
REQ-022 A byte is accepted only when byte_valid&&byte_ready; the accepted byte goes into buffer lane byte_idx (little-endian: first byte -> bits 7:0), and byte_idx increments.
REQ-023 Acceptance of the 4th byte (byte_idx==3) SHALL move LOAD -> WRITE; latency is last byte accepted at cycle t, mem_we high at t+1.
REQ-024 In WRITE: mem_we=1 for exactly one cycle, mem_addr=write pointer, mem_wdata=buffer, byte_ready=0, core_stall=1.
REQ-025 On leaving WRITE: write pointer+1, load_count+1, byte_idx=0, buffer zeroed; go to DONE if load_count reaches DEPTH or a load_end is pending, else go to LOAD.
REQ-026 load_end in LOAD with byte_idx==0 (after any byte accepted in the same cycle) SHALL go to DONE.
REQ-027 load_end in LOAD with byte_idx!=0 SHALL go to WRITE; the unfilled upper lanes are written as zero, then the FSM goes to DONE.
REQ-028 When load_end and an accepted byte occur in the same cycle, the byte SHALL be taken first; if it completes a word, WRITE then DONE.
REQ-029 In DONE: core_rst_pulse=1 for exactly one cycle, core_stall=1, then go to IDLE.
REQ-030 load_req outside IDLE, load_end outside LOAD, and byte_valid outside LOAD SHALL be ignored.
REQ-031 load_count SHALL hold its final value in IDLE until the next load_req.
REQ-032 The write pointer SHALL never exceed DEPTH-1; no write SHALL occur after DEPTH words.

Reset
REQ-033 rst_n low SHALL immediately force IDLE, byte_idx=0, buffer=0, pointer=0, load_count=0, mem_we=0, byte_ready=0, core_stall=0, core_rst_pulse=0, load_busy=0.
REQ-034 Reset during a load SHALL discard any partial word with no write; words already written remain, because the memory is not reset.

Verification
REQ-035 Reset, then fetch_addr=0x0000_000B -> mem_addr=2, mem_we=0, core_stall=0, load_busy=0.
REQ-036 load_req, then bytes 0x13,0x05,0x50,0x00 -> one-cycle mem_we with addr 0 and data 0x00500513, load_count=1, back in LOAD.
REQ-037 load_req, then 128 bytes with byte_valid held high -> 32 writes to addrs 0..31, auto DONE, single core_rst_pulse, load_count=32, core_stall=0 afterwards.
REQ-038 load_req, then bytes 11,22,33,44,AA,BB and load_end -> writes 0x44332211@0 and 0x0000BBAA@1, load_count=2, core_rst_pulse once.
REQ-039 load_req, 2 bytes, then rst_n pulsed low -> no mem_we, IDLE, core_stall=0, load_count=0.
REQ-040 byte_valid in IDLE and load_req during LOAD -> no effect: no write, and load_count/byte_idx are not cleared.
